if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0000_0000_0000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter NOP_INST, default 32'h0000_0013, instruction word presented to decode when no valid instruction is held.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports, in order:
- clk  input  1  clock, all state on posedge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- stall  input  1  decode cannot accept; hold outputs.
- flush  input  1  kill instruction currently presented to decode.
- redirect_valid  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  64  new fetch address.
- imem_req  output  1  one-cycle fetch request pulse.
- imem_addr  output  64  fetch address, valid with imem_req.
- imem_rvalid  input  1  fetch response strobe.
- imem_rdata  input  32  fetched instruction, valid with imem_rvalid.
- inst  output  32  instruction to decode.
- pc_out  output  64  address of inst.
- inst_valid  output  1  inst/pc_out hold a real instruction.
- pred_taken  output  1  inst was redirected by static prediction.

Function
REQ-005 SHALL keep at most one imem request outstanding; response latency 1..N cycles, unbounded.
REQ-006 SHALL implement states IDLE, REQ, WAIT, HOLD: IDLE->REQ first cycle after reset release; REQ drives imem_req=1, imem_addr=pc, ->WAIT; WAIT on imem_rvalid ->REQ (accepted or discarded) or ->HOLD (stall=1); HOLD ->REQ when stall=0.
REQ-007 On imem_rvalid in WAIT with stall=0 and no kill, SHALL register inst=imem_rdata, pc_out=pc, inst_valid=1, pc<=pc+4 (inst appears 1 cycle after rvalid).
REQ-008 On imem_rvalid with stall=1, SHALL capture rdata/pc into a 1-entry hold buffer; outputs unchanged; buffer moves to outputs the cycle stall drops.
REQ-009 While stall=1 and no redirect/flush, inst, pc_out, inst_valid, pred_taken SHALL remain constant and no new imem_req SHALL issue.
REQ-010 On redirect_valid, SHALL set pc<=redirect_pc with bits[1:0] forced to 0, clear hold buffer, set outputs to NOP_INST/inst_valid=0/pred_taken=0, and go REQ; if a request is outstanding, SHALL set kill and go WAIT, discarding the next imem_rvalid, then REQ.
REQ-011 redirect_valid SHALL take priority over stall, flush and a same-cycle imem_rvalid.
REQ-012 On flush without redirect, SHALL set outputs to NOP_INST/inst_valid=0 and clear hold buffer; pc and outstanding request unaffected.
REQ-013 pc increment SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC+4 = 0).
REQ-014 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.

Reset
REQ-015 rst=0 SHALL immediately force: state IDLE, pc=RESET_PC, kill=0, buffer empty, imem_req=0, imem_addr=RESET_PC, inst=NOP_INST, pc_out=0, inst_valid=0, pred_taken=0.
REQ-016 Reset mid-request SHALL abandon the outstanding request; its late response SHALL be ignored per REQ-014.

Configuration
REQ-017 Macro IF_STATIC_PREDICT_EN defined: an accepted instruction with opcode 7'b1101111 (jal) SHALL set pred_taken=1 and next pc = pc_out + sign-extended J immediate instead of pc+4; downstream redirect still overrides.
REQ-018 Macro IF_STATIC_PREDICT_EN undefined: pred_taken SHALL be tied 0 and pc always advances by 4 except on redirect.

Verification
REQ-019 Reset release, RESET_PC=0x1000, 1-cycle memory -> imem_addr 0x1000, 0x1004, 0x1008 on successive requests; inst_valid 1 with matching pc_out.
REQ-020 stall=1 for 3 cycles while response 0x00A00093 arrives -> outputs frozen, no imem_req; after release inst=0x00A00093 next cycle.
REQ-021 redirect_valid with redirect_pc=0x2002 during WAIT (3-cycle latency) -> stale response discarded, next imem_addr=0x2000, inst_valid=0 until new response.
REQ-022 redirect_valid and stall and imem_rvalid same cycle -> redirect wins, inst=0x00000013, inst_valid=0.
REQ-023 pc=0xFFFF_FFFF_FFFF_FFFC accepted -> next imem_addr=0; rst=0 asserted mid-WAIT -> all outputs at reset values, late rvalid ignored.
REQ-024 With IF_STATIC_PREDICT_EN, jal 0x0080006F at 0x100 -> pred_taken=1, next imem_addr=0x108; without macro -> next 0x104, pred_taken=0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with one outstanding imem request and a one-entry hold buffer.
// Define IF_STATIC_PREDICT_EN to make fetch follow jal targets (pred_taken); otherwise pc advances by 4.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] pc_out,
  output logic        inst_valid,
  output logic        pred_taken
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic        buf_pred_q, buf_pred_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        pred_q, pred_d;
  logic        rsp_pred;
  logic [63:0] rsp_next_pc;

`ifdef IF_STATIC_PREDICT_EN
  logic [63:0] j_imm;
  assign rsp_pred    = (imem_rdata[6:0] == 7'b1101111);
  assign j_imm       = {{44{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                        imem_rdata[30:21], 1'b0};
  assign rsp_next_pc = rsp_pred ? (pc_q + j_imm) : (pc_q + 64'd4);
`else
  assign rsp_pred    = 1'b0;
  assign rsp_next_pc = pc_q + 64'd4;
`endif

  // A request is only launched while decode can accept, so a stall never opens a new fetch.
  assign imem_req   = (state_q == REQ) && !stall;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign pc_out     = pc_out_q;
  assign inst_valid = valid_q;
  assign pred_taken = pred_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    buf_pred_d  = buf_pred_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    pred_d      = pred_q;

    // Decode consumes the presented instruction on every unstalled edge; refill or bubble.
    if (!stall || flush) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      pred_d  = 1'b0;
    end
    if (flush) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!stall) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (stall) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = imem_rdata;
            buf_pc_d    = pc_q;
            buf_pred_d  = rsp_pred;
            pc_d        = rsp_next_pc;
            state_d     = HOLD;
          end else begin
            inst_d   = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pred_d   = rsp_pred;
            pc_d     = rsp_next_pc;
            state_d  = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = REQ;
          if (buf_valid_q && !flush) begin
            inst_d      = buf_inst_q;
            pc_out_d    = buf_pc_q;
            valid_d     = 1'b1;
            pred_d      = buf_pred_q;
            buf_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; a request still in flight must have its response dropped.
    if (redirect_valid) begin
      pc_d        = redirect_pc & ~64'h3;
      buf_valid_d = 1'b0;
      inst_d      = NOP_INST;
      valid_d     = 1'b0;
      pred_d      = 1'b0;
      if (((state_q == WAIT) && !imem_rvalid) || imem_req) begin
        state_d = WAIT;
        kill_d  = 1'b1;
      end else begin
        state_d = REQ;
        kill_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= '0;
      buf_pc_q    <= '0;
      buf_pred_q  <= 1'b0;
      inst_q      <= NOP_INST;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      pred_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      buf_pred_q  <= buf_pred_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      pred_q      <= pred_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus a randomized run against a transaction-level fetch model.
// Compile with IF_STATIC_PREDICT_EN to check the jal-prediction build.
module tb_if_stage;

  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_STATIC_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [63:0] pc_out;
  logic        inst_valid;
  logic        pred_taken;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } item_t;

  if_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .pc_out(pc_out), .inst_valid(inst_valid), .pred_taken(pred_taken)
  );

  always #5 clk = ~clk;

  // Reference rules: jal (when prediction is built in) jumps by its J offset, else pc+4.
  function automatic bit modelPred(input logic [31:0] d);
    return PRED && (d[6:0] == 7'h6F);
  endfunction

  function automatic logic [63:0] modelNext(input logic [63:0] a, input logic [31:0] d);
    longint off;
    if (modelPred(d)) begin
      off = longint'({d[31], d[19:12], d[20], d[30:21], 1'b0});
      if (d[31]) off = off - 64'd2097152;
      return a + 64'(off);
    end
    return a + 64'd4;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] d;
    d = $urandom;
    if ($urandom_range(0, 7) == 0) d[6:0] = 7'h6F;
    else if (d[6:0] == 7'h6F) d[0] = 1'b0;
    return d;
  endfunction

  // Advance to 1 time unit after the next rising edge and drop the one-cycle pulses.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      nextCycle();
      #1;
    end
  endtask

  task automatic respond(input int lat, input logic [31:0] d);
    for (int i = 1; i <= lat; i++) begin
      nextCycle();
      if (i == lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = d;
      end
      #1;
    end
  endtask

  // Issued from a window where a request is going out; that request's response is stale.
  task automatic redirectFromReq(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    nextCycle();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    nextCycle();
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({imem_req, imem_addr, inst, pc_out, inst_valid, pred_taken} !==
        {1'b0, RPC, NOP, 64'h0, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL reset_values got req=%b addr=%h inst=%h pc=%h v=%b p=%b", imem_req, imem_addr, inst, pc_out, inst_valid, pred_taken); end
    nextCycle();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req got %b want 0", imem_req); end
    nextCycle();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC)
      begin errors++; $display("[TB] FAIL first_req got req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC); end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      waitReq(ok);
      checks++;
      if (!ok || imem_addr !== RPC + 64'(4 * k))
        begin errors++; $display("[TB] FAIL seq_addr%0d got ok=%b addr=%h want %h", k, ok, imem_addr, RPC + 64'(4 * k)); end
      d = 32'h0000_0093 | (32'(k + 1) << 20);
      respond(1, d);
      nextCycle();
      #1;
      checks++;
      if (inst !== d || pc_out !== RPC + 64'(4 * k) || inst_valid !== 1'b1)
        begin errors++; $display("[TB] FAIL seq_inst%0d got %h@%h v=%b want %h@%h v=1", k, inst, pc_out, inst_valid, d, RPC + 64'(4 * k)); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [97:0] snap;
    waitReq(ok);
    checks++;
    if (!ok || imem_addr !== 64'h100C) begin errors++; $display("[TB] FAIL stall_req got ok=%b addr=%h want 100c", ok, imem_addr); end
    nextCycle();
    stall       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0093;
    #1;
    snap = {inst, pc_out, inst_valid, pred_taken};
    for (int c = 2; c <= 4; c++) begin
      nextCycle();
      if (c == 4) stall = 1'b0;
      #1;
      checks++;
      if ({inst, pc_out, inst_valid, pred_taken} !== snap || imem_req !== 1'b0)
        begin errors++; $display("[TB] FAIL stall_frozen c%0d got %h req=%b want %h req=0", c, {inst, pc_out, inst_valid, pred_taken}, imem_req, snap); end
    end
    nextCycle();
    #1;
    checks++;
    if (inst !== 32'h00A0_0093 || pc_out !== 64'h100C || inst_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 64'h1010)
      begin errors++; $display("[TB] FAIL stall_release got %h@%h v=%b req=%b addr=%h want 00a00093@100c v=1 req=1 addr=1010", inst, pc_out, inst_valid, imem_req, imem_addr); end
  endtask

  task automatic test_flush();
    stall = 1'b1;
    flush = 1'b1;
    #1;
    nextCycle();
    #1;
    checks++;
    if (inst !== NOP || inst_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL flush_out got %h v=%b want %h v=0", inst, inst_valid, NOP); end
    stall = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1010)
      begin errors++; $display("[TB] FAIL flush_pc got req=%b addr=%h want 1 1010", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    bit ok;
    waitReq(ok);
    nextCycle();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    #1;
    for (int c = 2; c <= 3; c++) begin
      nextCycle();
      if (c == 3) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0)
        begin errors++; $display("[TB] FAIL redir_wait c%0d got v=%b req=%b want 0 0", c, inst_valid, imem_req); end
    end
    nextCycle();
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h2000)
      begin errors++; $display("[TB] FAIL redir_addr got v=%b req=%b addr=%h want 0 1 2000", inst_valid, imem_req, imem_addr); end
    respond(2, 32'h0020_0113);
    nextCycle();
    #1;
    checks++;
    if (inst !== 32'h0020_0113 || pc_out !== 64'h2000 || inst_valid !== 1'b1)
      begin errors++; $display("[TB] FAIL redir_inst got %h@%h v=%b want 00200113@2000 v=1", inst, pc_out, inst_valid); end
  endtask

  task automatic test_priority();
    bit ok;
    waitReq(ok);
    nextCycle();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h0030_0193;
    #1;
    nextCycle();
    #1;
    checks++;
    if (inst !== NOP || inst_valid !== 1'b0 || pred_taken !== 1'b0)
      begin errors++; $display("[TB] FAIL prio_out got %h v=%b p=%b want %h 0 0", inst, inst_valid, pred_taken, NOP); end
    stall = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h3000)
      begin errors++; $display("[TB] FAIL prio_req got req=%b addr=%h want 1 3000", imem_req, imem_addr); end
    respond(1, 32'h0000_0213);
    nextCycle();
    #1;
    checks++;
    if (inst !== 32'h0000_0213 || pc_out !== 64'h3000 || inst_valid !== 1'b1)
      begin errors++; $display("[TB] FAIL prio_inst got %h@%h v=%b want 00000213@3000 v=1", inst, pc_out, inst_valid); end
  endtask

  task automatic test_wrap_reset();
    redirectFromReq(64'hFFFF_FFFF_FFFF_FFFC);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      begin errors++; $display("[TB] FAIL wrap_req got req=%b addr=%h want 1 fffffffffffffffc", imem_req, imem_addr); end
    respond(1, 32'h0040_0213);
    nextCycle();
    #1;
    checks++;
    if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC || inst_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 64'h0)
      begin errors++; $display("[TB] FAIL wrap_next got pc=%h v=%b req=%b addr=%h want fffffffffffffffc 1 1 0", pc_out, inst_valid, imem_req, imem_addr); end
    nextCycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, inst, pc_out, inst_valid, pred_taken} !==
        {1'b0, RPC, NOP, 64'h0, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL midwait_reset got req=%b addr=%h inst=%h pc=%h v=%b p=%b", imem_req, imem_addr, inst, pc_out, inst_valid, pred_taken); end
    nextCycle();
    #1;
    nextCycle();
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0040_0213;
    #1;
    nextCycle();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0040_0213;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1 || imem_addr !== RPC)
      begin errors++; $display("[TB] FAIL late_rvalid got %h v=%b req=%b addr=%h want %h 0 1 %h", inst, inst_valid, imem_req, imem_addr, NOP, RPC); end
    respond(1, 32'h0050_0293);
    nextCycle();
    #1;
    checks++;
    if (inst !== 32'h0050_0293 || pc_out !== RPC || inst_valid !== 1'b1)
      begin errors++; $display("[TB] FAIL post_reset got %h@%h v=%b want 00500293@%h v=1", inst, pc_out, inst_valid, RPC); end
  endtask

  task automatic test_predict();
    logic [31:0] d;
    d = 32'h0080_006F;
    redirectFromReq(64'h100);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h100)
      begin errors++; $display("[TB] FAIL pred_req got req=%b addr=%h want 1 100", imem_req, imem_addr); end
    respond(1, d);
    nextCycle();
    #1;
    checks++;
    if (inst !== d || pc_out !== 64'h100 || pred_taken !== modelPred(d) || imem_addr !== modelNext(64'h100, d))
      begin errors++; $display("[TB] FAIL pred_jal got %h@%h p=%b next=%h want p=%b next=%h", inst, pc_out, pred_taken, imem_addr, modelPred(d), modelNext(64'h100, d)); end
  endtask

  task automatic test_random();
    item_t q[$];
    item_t e;
    logic [63:0] expAddr, paddr;
    logic [31:0] pdata;
    logic [97:0] prevOut;
    bit pending, prevStall;
    int cd, consumed;
    stall = 1'b0;
    rst   = 1'b0;
    #1;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    #1;
    expAddr = RPC;
    pending = 1'b0;
    prevStall = 1'b0;
    prevOut = '0;
    consumed = 0;
    cd = 0;
    paddr = '0;
    pdata = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      nextCycle();
      stall = ($urandom_range(0, 3) == 0);
      if (pending) begin
        if (cd == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pdata;
          q.push_back('{a: paddr, d: pdata});
          expAddr = modelNext(paddr, pdata);
          pending = 1'b0;
        end else begin
          cd--;
        end
      end
      #1;
      if (imem_req === 1'b1) begin
        checks++;
        if (stall || pending || imem_addr !== expAddr)
          begin errors++; $display("[TB] FAIL rnd_req cyc%0d got addr=%h stall=%b pend=%b want %h", cyc, imem_addr, stall, pending, expAddr); end
        pending = 1'b1;
        paddr   = imem_addr;
        pdata   = randInst();
        cd      = $urandom_range(0, 3);
      end
      if (prevStall) begin
        checks++;
        if ({inst, pc_out, inst_valid, pred_taken} !== prevOut)
          begin errors++; $display("[TB] FAIL rnd_frozen cyc%0d got %h want %h", cyc, {inst, pc_out, inst_valid, pred_taken}, prevOut); end
      end
      if (inst_valid === 1'b1 && !stall) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("[TB] FAIL rnd_extra cyc%0d got %h@%h want none", cyc, inst, pc_out);
        end else begin
          e = q.pop_front();
          consumed++;
          if (inst !== e.d || pc_out !== e.a || pred_taken !== modelPred(e.d))
            begin errors++; $display("[TB] FAIL rnd_inst cyc%0d got %h@%h p=%b want %h@%h p=%b", cyc, inst, pc_out, pred_taken, e.d, e.a, modelPred(e.d)); end
        end
      end
      prevOut   = {inst, pc_out, inst_valid, pred_taken};
      prevStall = stall;
    end
    checks++;
    if (consumed < 100 || q.size() > 2)
      begin errors++; $display("[TB] FAIL rnd_progress got consumed=%0d left=%0d want >=100 <=2", consumed, q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_redirect();
    test_priority();
    test_wrap_reset();
    test_predict();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
